lza_pipelined_counter: RTL and testbench
========================================

LZA_PIPELINED_COUNTER -- requirements
Module: lza_pipelined_counter

Interface
REQ-001 SHALL have parameter SWR, default 26: significand/adder width in bits, minimum 8.
REQ-002 SHALL have parameter GW, default 8: leading-zero group width, 2..SWR.
REQ-003 SHALL have derived localparam CW = clog2(SWR+1): count width.
REQ-004 SHALL have port clk, input, 1: the single clock, rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port valid_i, input, 1: input operand valid.
REQ-007 SHALL have port ready_o, output, 1: block accepts an input this cycle.
REQ-008 SHALL have port P_i, input, SWR: adder propagate vector.
REQ-009 SHALL have port C_i, input, SWR-1 (bits SWR-1:1): carry into bits SWR-1..1.
REQ-010 SHALL have port A_S_i, input, 1: add/subtract select, used as carry into bit 0.
REQ-011 SHALL have port valid_o, output, 1: result valid.
REQ-012 SHALL have port ready_i, input, 1: downstream accepts the result.
REQ-013 SHALL have port S_o, output, SWR: registered inverted-sum vector.
REQ-014 SHALL have port LZ_o, output, CW: leading-zero count of the sum.
REQ-015 SHALL have port zero_o, output, 1: sum is all zeros.

Function
REQ-016 SHALL form the sum as sum[0] = A_S_i XOR P_i[0] and, for j>=1, sum[j] = P_i[j] XOR C_i[j].
REQ-017 SHALL form the inverted sum as S[j] = NOT sum[j] for all j.
REQ-018 SHALL use a two-stage pipeline.
REQ-019 Stage 1 SHALL register S plus, per GW-bit group taken from the MSB, the group leading-zero count and a group-all-zero flag; the LSB group may be narrower.
REQ-020 Stage 2 SHALL combine the groups with a priority encoder: LZ = (index of first non-zero group) x GW + that group's count.
REQ-021 SHALL force LZ_o = SWR and zero_o = 1 when the sum is all zeros; zero_o SHALL be 0 otherwise.
REQ-022 Latency SHALL be 2 cycles from accepted input (valid_i & ready_o) to valid_o, with no stall.
REQ-023 Throughput SHALL be 1 result per cycle.
REQ-024 Handshake: a stage register SHALL load when it is empty or its contents move on in the same cycle.
REQ-025 ready_o SHALL equal (~stage1_valid) | (~valid_o) | ready_i.
REQ-026 Stall: while valid_o & ~ready_i, S_o, LZ_o and zero_o SHALL hold stable.
REQ-027 A full pipeline SHALL hold exactly 2 results with no loss, duplication or reordering.
REQ-028 Simultaneous accept and drain in one cycle SHALL keep occupancy constant.
REQ-029 SHALL not register inputs when valid_i = 0; data registers may hold stale values.

Reset
REQ-030 rst SHALL asynchronously clear both stage valid bits.
REQ-031 rst SHALL clear S_o, LZ_o and zero_o to 0.
REQ-032 During rst, valid_o SHALL be 0 and ready_o SHALL be 1.
REQ-033 Reset mid-operation SHALL discard in-flight results; the first post-reset valid_o SHALL come only from an input accepted after rst deasserts.

Structure
REQ-034 SHALL place the clog2 function and the default SWR/GW constants in the shared FPU package/include.
REQ-035 SHALL use one sub-module, lza_group_encoder (parameter GW), for the per-group count and all-zero flag, instantiated ceil(SWR/GW) times.

Verification (SWR=26, GW=8)
REQ-036 SHALL check: P_i=0, C_i=0, A_S_i=1 -> 2 cycles later valid_o=1, LZ_o=25, zero_o=0, S_o=26'h3FFFFFE.
REQ-037 SHALL check: P_i=26'h0200000, C_i=0, A_S_i=0 -> LZ_o=4, zero_o=0.
REQ-038 SHALL check: P_i=0, C_i=0, A_S_i=0 -> LZ_o=26, zero_o=1, S_o=26'h3FFFFFF.
REQ-039 SHALL check: P_i[0]=1 with A_S_i=1 and all other bits 0 -> sum all zero, LZ_o=26, zero_o=1.
REQ-040 SHALL check: 3 back-to-back inputs with ready_i=0 for 4 cycles -> ready_o=0 once 2 results are held, the 3rd input is stalled, and after ready_i=1 all 3 results emerge in order, unchanged.
REQ-041 SHALL check: rst pulsed while valid_o=1 -> valid_o=0 and LZ_o=0 immediately, before the next clk edge; the next result appears 2 cycles after a new accept.

Source files
------------

// File: rtl/lza_pipelined_counter_pkg.sv
// lza_pipelined_counter_pkg: shared width helper and default adder/group sizes
package lza_pipelined_counter_pkg;
    localparam int SWR_DEF = 26;
    localparam int GW_DEF = 8;
    function automatic int clog2(input int n);
        int r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction
endpackage

// File: rtl/lza_pipelined_counter_group_encoder.sv
// lza_group_encoder: leading-zero count and all-zero flag of one GW-bit group
module lza_group_encoder
    import lza_pipelined_counter_pkg::*;
#(
    parameter int GW = GW_DEF,
    localparam int GCW = clog2(GW + 1)
) (
    input  logic [GW-1:0]  d,
    output logic [GCW-1:0] cnt,
    output logic           zero
);
    always_comb begin
        cnt = GCW'(GW);
        for (int i = 0; i < GW; i++)
            if (d[i]) cnt = GCW'(GW - 1 - i);
    end
    assign zero = ~|d;
endmodule

// File: rtl/lza_pipelined_counter.sv
// lza_pipelined_counter: two-stage leading-zero count of the adder sum with valid/ready flow control
module lza_pipelined_counter
    import lza_pipelined_counter_pkg::*;
#(
    parameter int SWR = SWR_DEF,
    parameter int GW = GW_DEF,
    localparam int CW = clog2(SWR + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           valid_i,
    output logic           ready_o,
    input  logic [SWR-1:0] P_i,
    input  logic [SWR-1:1] C_i,
    input  logic           A_S_i,
    output logic           valid_o,
    input  logic           ready_i,
    output logic [SWR-1:0] S_o,
    output logic [CW-1:0]  LZ_o,
    output logic           zero_o
);
    localparam int NG = (SWR + GW - 1) / GW;
    localparam int PW = NG * GW;
    localparam int GCW = clog2(GW + 1);
    logic [SWR-1:0] sum, s1_s;
    logic [PW-1:0] sum_pad;
    logic [NG-1:0][GCW-1:0] grp_cnt, s1_cnt;
    logic [NG-1:0] grp_zero, s1_zero;
    logic s1_valid, ld1, ld2;
    logic [CW-1:0] lz;
    assign sum = P_i ^ {C_i, A_S_i};
    // zero padding below the LSB group never hides a set bit and keeps an empty group empty
    assign sum_pad = PW'(sum) << (PW - SWR);
    for (genvar g = 0; g < NG; g++) begin : g_grp
        lza_group_encoder #(.GW(GW)) u_enc (
            .d(sum_pad[PW-1-g*GW -: GW]),
            .cnt(grp_cnt[g]),
            .zero(grp_zero[g])
        );
    end
    assign ld2 = ~valid_o | ready_i;
    assign ld1 = ~s1_valid | ld2;
    assign ready_o = ld1;
    // group 0 is the MSB group, so the lowest non-zero index is written last and wins
    always_comb begin
        lz = CW'(SWR);
        for (int g = NG - 1; g >= 0; g--)
            if (!s1_zero[g]) lz = CW'(g * GW) + CW'(s1_cnt[g]);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            valid_o <= 1'b0;
            s1_s <= '0;
            s1_cnt <= '0;
            s1_zero <= '0;
            S_o <= '0;
            LZ_o <= '0;
            zero_o <= 1'b0;
        end else begin
            if (ld1) s1_valid <= valid_i;
            if (ld1 && valid_i) begin
                s1_s <= ~sum;
                s1_cnt <= grp_cnt;
                s1_zero <= grp_zero;
            end
            if (ld2) valid_o <= s1_valid;
            if (ld2 && s1_valid) begin
                S_o <= s1_s;
                LZ_o <= lz;
                zero_o <= &s1_zero;
            end
        end
    end
endmodule

// File: tb/tb_lza_pipelined_counter.sv
// tb_lza_pipelined_counter: scoreboard bench for the pipelined leading-zero counter
module tb_lza_pipelined_counter;
    localparam int SWR = 26;
    localparam int CW = 5;
    typedef struct packed {
        logic [SWR-1:0] s;
        logic [CW-1:0]  lz;
        logic           z;
    } res_t;

    logic clk = 0, rst = 1, valid_i = 0, ready_i = 1, A_S_i = 0;
    logic ready_o, valid_o, zero_o;
    logic [SWR-1:0] P_i = '0, S_o;
    logic [SWR-1:1] C_i = '0;
    logic [CW-1:0] LZ_o;
    res_t q[$];
    int pass_cnt = 0, total_cnt = 0;

    logic [SWR-1:0] tp[4] = '{26'h0, 26'h0200000, 26'h0, 26'h1};
    logic tas[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int tlz[4] = '{25, 4, 26, 26};
    logic tz[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [SWR-1:0] ts[4] = '{26'h3FFFFFE, 26'h3DFFFFF, 26'h3FFFFFF, 26'h3FFFFFF};
    logic [SWR-1:0] bp[3] = '{26'h0100000, 26'h0000400, 26'h0000008};

    always #5 clk = ~clk;

    lza_pipelined_counter dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o),
        .P_i(P_i), .C_i(C_i), .A_S_i(A_S_i), .valid_o(valid_o),
        .ready_i(ready_i), .S_o(S_o), .LZ_o(LZ_o), .zero_o(zero_o)
    );

    function automatic res_t model(input logic [SWR-1:0] p, input logic [SWR-1:1] c, input logic as);
        logic [SWR-1:0] sm;
        res_t r;
        sm = p ^ {c, as};
        r.s = ~sm;
        r.z = (sm == '0);
        r.lz = CW'(SWR);
        for (int i = SWR - 1; i >= 0; i--)
            if (sm[i]) begin
                r.lz = CW'(SWR - 1 - i);
                break;
            end
        return r;
    endfunction

    // one clock: sample at negedge, pop on output handshake, push on input handshake
    task automatic tick(output bit fired, output res_t exp_r, output res_t act);
        @(negedge clk);
        fired = valid_o && ready_i;
        act = {S_o, LZ_o, zero_o};
        exp_r = 'x;
        if (fired && q.size() > 0) exp_r = q.pop_front();
        if (valid_i && ready_o) q.push_back(model(P_i, C_i, A_S_i));
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #3;
        total_cnt++;
        if ({valid_o, ready_o} !== 2'b01) $display("FAIL reset_handshake: got %b, expected 01", {valid_o, ready_o});
        else pass_cnt++;
        total_cnt++;
        if ({S_o, LZ_o, zero_o} !== '0) $display("FAIL reset_data: got %h, expected 0", {S_o, LZ_o, zero_o});
        else pass_cnt++;
        @(posedge clk);
        #1;
        rst = 0;
        @(posedge clk);
        #1;
        total_cnt++;
        if (valid_o !== 1'b0) $display("FAIL post_reset_valid: got %b, expected 0", valid_o);
        else pass_cnt++;
    endtask

    task automatic test_spec_vectors();
        bit f;
        res_t e, a;
        ready_i = 1;
        for (int k = 0; k < 4; k++) begin
            P_i = tp[k];
            C_i = '0;
            A_S_i = tas[k];
            valid_i = 1;
            tick(f, e, a);
            valid_i = 0;
            total_cnt++;
            if (valid_o !== 1'b0) $display("FAIL latency_early[%0d]: got %b, expected 0", k, valid_o);
            else pass_cnt++;
            tick(f, e, a);
            total_cnt++;
            if (valid_o !== 1'b1) $display("FAIL latency_valid[%0d]: got %b, expected 1", k, valid_o);
            else pass_cnt++;
            total_cnt++;
            if (LZ_o !== CW'(tlz[k])) $display("FAIL spec_lz[%0d]: got %0d, expected %0d", k, LZ_o, tlz[k]);
            else pass_cnt++;
            total_cnt++;
            if (zero_o !== tz[k]) $display("FAIL spec_zero[%0d]: got %b, expected %b", k, zero_o, tz[k]);
            else pass_cnt++;
            total_cnt++;
            if (S_o !== ts[k]) $display("FAIL spec_s[%0d]: got %h, expected %h", k, S_o, ts[k]);
            else pass_cnt++;
            tick(f, e, a);
            total_cnt++;
            if (!f || a !== e) $display("FAIL spec_sb[%0d]: fired %b got %h, expected %h", k, f, a, e);
            else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back();
        bit f;
        res_t e, a, hold;
        int fires = 0;
        C_i = '0;
        A_S_i = 0;
        ready_i = 0;
        valid_i = 1;
        P_i = bp[0];
        tick(f, e, a);
        P_i = bp[1];
        tick(f, e, a);
        total_cnt++;
        if (ready_o !== 1'b0) $display("FAIL full_ready: got %b, expected 0", ready_o);
        else pass_cnt++;
        total_cnt++;
        if (LZ_o !== 5'd5) $display("FAIL full_first_lz: got %0d, expected 5", LZ_o);
        else pass_cnt++;
        hold = {S_o, LZ_o, zero_o};
        P_i = bp[2];
        tick(f, e, a);
        tick(f, e, a);
        total_cnt++;
        if ({S_o, LZ_o, zero_o} !== hold) $display("FAIL stall_hold: got %h, expected %h", {S_o, LZ_o, zero_o}, hold);
        else pass_cnt++;
        total_cnt++;
        if (ready_o !== 1'b0 || valid_o !== 1'b1) $display("FAIL stall_flags: got %b%b, expected 01", ready_o, valid_o);
        else pass_cnt++;
        total_cnt++;
        if (q.size() !== 2) $display("FAIL occupancy: got %0d, expected 2", q.size());
        else pass_cnt++;
        ready_i = 1;
        for (int n = 0; n < 6; n++) begin
            tick(f, e, a);
            valid_i = 0;
            if (f) begin
                fires++;
                total_cnt++;
                if (a !== e) $display("FAIL b2b_order[%0d]: got %h, expected %h", fires, a, e);
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (fires !== 3 || q.size() !== 0) $display("FAIL b2b_count: got %0d left %0d, expected 3 left 0", fires, q.size());
        else pass_cnt++;
    endtask

    task automatic test_stream();
        bit f;
        res_t e, a;
        logic [31:0] r1, r2;
        for (int n = 0; n < 400; n++) begin
            valid_i = $urandom_range(0, 3) != 0;
            ready_i = $urandom_range(0, 3) != 0;
            r1 = $urandom;
            r2 = $urandom;
            P_i = r1[SWR-1:0] >> $urandom_range(0, SWR);
            C_i = r2[SWR-2:0] >> $urandom_range(0, SWR);
            A_S_i = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) begin
                C_i = P_i[SWR-1:1];
                A_S_i = P_i[0];
            end
            tick(f, e, a);
            if (f) begin
                total_cnt++;
                if (a !== e) $display("FAIL stream[%0d]: got %h, expected %h", n, a, e);
                else pass_cnt++;
            end
        end
        valid_i = 0;
        ready_i = 1;
        for (int n = 0; n < 4; n++) begin
            tick(f, e, a);
            if (f) begin
                total_cnt++;
                if (a !== e) $display("FAIL stream_drain[%0d]: got %h, expected %h", n, a, e);
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (q.size() !== 0) $display("FAIL stream_left: got %0d, expected 0", q.size());
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        bit f;
        res_t e, a;
        ready_i = 0;
        P_i = '0;
        C_i = '0;
        A_S_i = 1;
        valid_i = 1;
        tick(f, e, a);
        P_i = 26'h0000010;
        tick(f, e, a);
        valid_i = 0;
        total_cnt++;
        if (valid_o !== 1'b1 || LZ_o !== 5'd25) $display("FAIL mid_setup: got %b/%0d, expected 1/25", valid_o, LZ_o);
        else pass_cnt++;
        rst = 1;
        #1;
        total_cnt++;
        if ({valid_o, ready_o} !== 2'b01) $display("FAIL mid_rst_flags: got %b, expected 01", {valid_o, ready_o});
        else pass_cnt++;
        total_cnt++;
        if ({S_o, LZ_o, zero_o} !== '0) $display("FAIL mid_rst_data: got %h, expected 0", {S_o, LZ_o, zero_o});
        else pass_cnt++;
        q.delete();
        @(negedge clk);
        rst = 0;
        @(posedge clk);
        #1;
        ready_i = 1;
        for (int n = 0; n < 3; n++) begin
            tick(f, e, a);
            total_cnt++;
            if (f) $display("FAIL mid_stale[%0d]: got fired 1, expected 0", n);
            else pass_cnt++;
        end
        P_i = 26'h0000800;
        A_S_i = 0;
        valid_i = 1;
        tick(f, e, a);
        valid_i = 0;
        total_cnt++;
        if (valid_o !== 1'b0) $display("FAIL mid_early: got %b, expected 0", valid_o);
        else pass_cnt++;
        tick(f, e, a);
        total_cnt++;
        if (valid_o !== 1'b1 || LZ_o !== 5'd14) $display("FAIL mid_new: got %b/%0d, expected 1/14", valid_o, LZ_o);
        else pass_cnt++;
        tick(f, e, a);
        total_cnt++;
        if (!f || a !== e) $display("FAIL mid_sb: fired %b got %h, expected %h", f, a, e);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_spec_vectors();
        test_back_to_back();
        test_stream();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
